// File: rtl/cpu16_pkg.sv
// Shared CPU16 datapath widths and word types.
package cpu16_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SHAMT_W = 5;

  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

endpackage

// File: rtl/sll_stage.sv
// One level of the logarithmic shifter: shift by SHIFT when en, tracking the last bit pushed out of the MSB.
module sll_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SHIFT  = 1
) (
  input  logic [DATA_W-1:0] data,
  input  logic              carry,
  input  logic              en,
  output logic [DATA_W-1:0] shifted_c,
  output logic              carry_c
);

  // Lowest of the bits leaving the top is the one shifted out last.
  localparam int unsigned CIDX = DATA_W - SHIFT;

  assign shifted_c = en ? (data << SHIFT) : data;
  assign carry_c   = en ? data[CIDX] : carry;

endmodule

// File: rtl/sll_unit.sv
// 16-bit logical shift-left unit for the CPU16 ALU with a registered result and flags.
module sll_unit
  import cpu16_pkg::*;
#(
  parameter int unsigned DATA_W  = cpu16_pkg::DATA_W,
  parameter int unsigned SHAMT_W = cpu16_pkg::SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  A,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  output logic [DATA_W-1:0]  dalja,
  output logic               zero,
  output logic               cout
);

  logic [DATA_W-1:0] lvl_data  [SHAMT_W+1];
  logic              lvl_carry [SHAMT_W+1];

  assign lvl_data[0]  = A;
  assign lvl_carry[0] = 1'b0;

  // Barrel shifter: level k shifts by 2**k; the last level clears the word.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
    sll_stage #(
      .DATA_W (DATA_W),
      .SHIFT  (32'(1) << k)
    ) u_stage (
      .data      (lvl_data[k]),
      .carry     (lvl_carry[k]),
      .en        (shamt[k]),
      .shifted_c (lvl_data[k+1]),
      .carry_c   (lvl_carry[k+1])
    );
  end

  logic [DATA_W-1:0] result_c;
  logic              zero_c;

  assign result_c = lvl_data[SHAMT_W];
  assign zero_c   = (result_c == '0);

  // Output stage: load on in_valid, otherwise hold the result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dalja     <= '0;
      zero      <= 1'b1;
      cout      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        dalja <= result_c;
        zero  <= zero_c;
        cout  <= lvl_carry[SHAMT_W];
      end
    end
  end

endmodule

// File: tb/tb_sll_unit.sv
// Directed self-checking bench for sll_unit.
module tb_sll_unit;
  import cpu16_pkg::*;

  logic   clk;
  logic   rst_n;
  logic   in_valid;
  word_t  A;
  shamt_t shamt;
  logic   out_valid;
  word_t  dalja;
  logic   zero;
  logic   cout;

  int errors = 0;
  int checks = 0;

  sll_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .shamt     (shamt),
    .out_valid (out_valid),
    .dalja     (dalja),
    .zero      (zero),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input word_t a, input shamt_t s);
    @(negedge clk);
    in_valid = v;
    A        = a;
    shamt    = s;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    A        = '0;
    shamt    = '0;
    rst_n    = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (dalja !== 16'h0000) begin errors++; $display("FAIL reset_dalja got=%h exp=0000", dalja); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", zero); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_vectors();
    word_t  va [10] = '{16'd3, 16'd5, 16'h8001, 16'h0001, 16'hFFFF,
                        16'hFFFF, 16'hA5A5, 16'h4000, 16'h1234, 16'h1234};
    shamt_t vs [10] = '{5'd2, 5'd3, 5'd1, 5'd15, 5'd16,
                        5'd20, 5'd0, 5'd2, 5'd4, 5'd8};
    word_t  vd [10] = '{16'd12, 16'd40, 16'h0002, 16'h8000, 16'h0000,
                        16'h0000, 16'hA5A5, 16'h0000, 16'h2340, 16'h3400};
    logic   vc [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                        1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, va[i], vs[i]);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_valid got=%b exp=1", i, out_valid); end
      checks++; if (dalja !== vd[i]) begin errors++; $display("FAIL vec%0d_dalja got=%h exp=%h", i, dalja, vd[i]); end
      checks++; if (zero !== (vd[i] == 16'h0000)) begin errors++; $display("FAIL vec%0d_zero got=%b exp=%b", i, zero, vd[i] == 16'h0000); end
      checks++; if (cout !== vc[i]) begin errors++; $display("FAIL vec%0d_cout got=%b exp=%b", i, cout, vc[i]); end
    end
    drive(1'b0, '0, '0);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    word_t  ba [3] = '{16'h0001, 16'h00FF, 16'hC000};
    shamt_t bs [3] = '{5'd4, 5'd8, 5'd1};
    word_t  bd [3] = '{16'h0010, 16'hFF00, 16'h8000};
    logic   bc [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ba[i], bs[i]);
      if (i > 0) begin
        checks++; if (dalja !== bd[i-1]) begin errors++; $display("FAIL b2b%0d_prev_dalja got=%h exp=%h", i, dalja, bd[i-1]); end
      end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b%0d_valid got=%b exp=1", i, out_valid); end
      checks++; if (dalja !== bd[i]) begin errors++; $display("FAIL b2b%0d_dalja got=%h exp=%h", i, dalja, bd[i]); end
      checks++; if (cout !== bc[i]) begin errors++; $display("FAIL b2b%0d_cout got=%b exp=%b", i, cout, bc[i]); end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 16'h0003, 5'd14);
    @(posedge clk); #1;
    checks++; if (dalja !== 16'hC000) begin errors++; $display("FAIL hold_load_dalja got=%h exp=c000", dalja); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL hold_load_cout got=%b exp=0", cout); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 'x, 5'd1);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold%0d_valid got=%b exp=0", i, out_valid); end
      checks++; if (dalja !== 16'hC000) begin errors++; $display("FAIL hold%0d_dalja got=%h exp=c000", i, dalja); end
      checks++; if (zero !== 1'b0) begin errors++; $display("FAIL hold%0d_zero got=%b exp=0", i, zero); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL hold%0d_cout got=%b exp=0", i, cout); end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 16'h8001, 5'd1);
    @(posedge clk); #1;
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ares_pre_cout got=%b exp=1", cout); end
    drive(1'b1, 16'h00F0, 5'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ares_valid got=%b exp=0", out_valid); end
    checks++; if (dalja !== 16'h0000) begin errors++; $display("FAIL ares_dalja got=%h exp=0000", dalja); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL ares_zero got=%b exp=1", zero); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL ares_cout got=%b exp=0", cout); end
    @(posedge clk); #1;
    checks++; if (dalja !== 16'h0000) begin errors++; $display("FAIL ares_held_dalja got=%h exp=0000", dalja); end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ares_release%0d_valid got=%b exp=0", i, out_valid); end
      checks++; if (dalja !== 16'h0000) begin errors++; $display("FAIL ares_release%0d_dalja got=%h exp=0000", i, dalja); end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
